// File: rtl/pulse_meter_if.sv
// pulse_meter_if: control, status and result signals of one pulse_meter instance
interface pulse_meter_if #(parameter int WIDTH = 16);
    logic             arm;
    logic             cancel;
    logic             level;
    logic [WIDTH-1:0] timeout;
    logic             sig_in;
    logic             busy;
    logic             width_valid;
    logic [WIDTH-1:0] width;
    logic             overflow;
    logic             timed_out;
    logic             ack;

    modport master (
        output arm, cancel, level, timeout, sig_in, ack,
        input  busy, width_valid, width, overflow, timed_out
    );

    modport slave (
        input  arm, cancel, level, timeout, sig_in, ack,
        output busy, width_valid, width, overflow, timed_out
    );
endinterface

// File: rtl/signal_sync.sv
// signal_sync: multi-flop synchronizer for an asynchronous input plus one delay flop
// so downstream logic can detect edges on the synchronized signal.
module signal_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic sig_s,
    output logic sig_d
);
    logic [SYNC_STAGES-1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            sig_d <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], sig_in};
            sig_d <= sync[SYNC_STAGES-1];
        end
    end

    assign sig_s = sync[SYNC_STAGES-1];
endmodule

// File: rtl/pulse_meter.sv
// pulse_meter: armed single-shot measurement of a pulse width in clk cycles,
// with start timeout, counter saturation and a valid/ack result handshake.
module pulse_meter #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic          clk,
    input logic          rst_n,
    pulse_meter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_START, MEASURE, REPORT} state_t;

    state_t           state;
    logic             sig_s, sig_d, level_q;
    logic [WIDTH-1:0] timeout_q, cnt;
    logic             act, act_d, start, cnt_max;
    logic [WIDTH-1:0] cnt_inc;

    signal_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst_n(rst_n), .sig_in(bus.sig_in), .sig_s(sig_s), .sig_d(sig_d)
    );

    assign act     = (sig_s == level_q);
    assign act_d   = (sig_d == level_q);
    assign start   = act & ~act_d;
    assign cnt_max = &cnt;
    assign cnt_inc = cnt_max ? cnt : cnt + WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            level_q         <= 1'b0;
            timeout_q       <= '0;
            cnt             <= '0;
            bus.busy        <= 1'b0;
            bus.width_valid <= 1'b0;
            bus.width       <= '0;
            bus.overflow    <= 1'b0;
            bus.timed_out   <= 1'b0;
        end else if (bus.cancel) begin
            state           <= IDLE;
            bus.busy        <= 1'b0;
            bus.width_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.arm) begin
                    state         <= WAIT_START;
                    level_q       <= bus.level;
                    timeout_q     <= bus.timeout;
                    cnt           <= '0;
                    bus.busy      <= 1'b1;
                    bus.width     <= '0;
                    bus.overflow  <= 1'b0;
                    bus.timed_out <= 1'b0;
                end
                WAIT_START: begin
                    // a start edge wins over a timeout landing on the same cycle
                    if (start) begin
                        state <= MEASURE;
                        cnt   <= WIDTH'(1);
                    end else if (timeout_q != '0 && cnt_inc == timeout_q) begin
                        state           <= REPORT;
                        bus.busy        <= 1'b0;
                        bus.width_valid <= 1'b1;
                        bus.timed_out   <= 1'b1;
                        bus.width       <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                MEASURE: begin
                    if (act) begin
                        cnt <= cnt_inc;
                        if (cnt_max) bus.overflow <= 1'b1;
                    end else begin
                        state           <= REPORT;
                        bus.busy        <= 1'b0;
                        bus.width_valid <= 1'b1;
                        bus.width       <= cnt;
                    end
                end
                REPORT: if (bus.ack) begin
                    state           <= IDLE;
                    bus.width_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: randomized captures scored against a waveform-level reference model.
module tb_pulse_meter;
    localparam int W   = 4;
    localparam int S   = 2;
    localparam int MAX = (1 << W) - 1;

    typedef struct {
        int width;
        int ovf;
        int to;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pulse_meter_if #(.WIDTH(W)) bus();
    pulse_meter #(.WIDTH(W), .SYNC_STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t q[$];
    bit   plan[$];
    bit   plan_pre, plan_lvl;
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int req);
        vectors++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, req, $time);
        end
    endtask

    // whether the synchronized input is active at plan index j (index = edges after arm)
    function automatic bit av(input int j);
        if (j <= 0) return plan_pre == plan_lvl;
        if (j >= plan.size()) return 1'b0;
        return plan[j] == plan_lvl;
    endfunction

    // sig_s seen at edge k+i reflects sig_in sampled S edges earlier; a pulse is a
    // fresh inactive->active transition of that delayed view, width = its run length
    function automatic exp_t model(input int t, input int k);
        exp_t e;
        int n;
        for (int i = 1; i < 1000; i++) begin
            if (av(i - S) && !av(i - S - 1)) begin
                n = 0;
                while (av(i + n - S)) n++;
                e.width = (n > MAX) ? MAX : n;
                e.ovf   = (n > MAX) ? 1 : 0;
                e.to    = 0;
                e.cyc   = k + i + n;
                return e;
            end
            if (t != 0 && i == t) begin
                e.width = 0; e.ovf = 0; e.to = 1; e.cyc = k + t;
                return e;
            end
        end
        e.width = -1; e.ovf = -1; e.to = -1; e.cyc = -1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input bit lvl, input int t, input bit pre_act, input int gap,
                           input int n, input int hold, input bit arm_ack);
        int k, b;
        plan_lvl = lvl;
        plan_pre = pre_act ? lvl : ~lvl;
        plan.delete();
        plan.push_back(plan_pre);
        repeat (gap) plan.push_back(~lvl);
        repeat (n) plan.push_back(lvl);
        repeat (S + 3) plan.push_back(~lvl);
        bus.sig_in = plan_pre;
        repeat (S + 2) tick();
        bus.level   = lvl;
        bus.timeout = W'(t);
        bus.arm     = 1'b1;
        tick();
        k = cyc;
        bus.arm     = 1'b0;
        bus.level   = 1'($urandom);
        bus.timeout = W'($urandom);
        check("busy_after_arm", int'(bus.busy), 1);
        q.push_back(model(t, k));
        for (int j = 1; j < plan.size(); j++) begin
            bus.sig_in = plan[j];
            tick();
        end
        b = 0;
        while (!bus.width_valid && b < 100) begin
            tick();
            b++;
        end
        if (!bus.width_valid) begin
            check("valid_wait", 0, 1);
            return;
        end
        repeat (hold) tick();
        bus.ack = 1'b1;
        bus.arm = arm_ack;
        tick();
        bus.ack = 1'b0;
        bus.arm = 1'b0;
        check("valid_after_ack", int'(bus.width_valid), 0);
        check("busy_after_ack", int'(bus.busy), 0);
        if (arm_ack) begin
            tick();
            check("arm_ack_ignored", int'(bus.busy), 0);
        end
    endtask

    initial begin : monitor
        exp_t cur;
        bit   pv = 1'b0;
        bit   have = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.width_valid && !pv) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                    have = 1'b0;
                end else begin
                    cur  = q.pop_front();
                    have = 1'b1;
                    check("width", int'(bus.width), cur.width);
                    check("overflow", int'(bus.overflow), cur.ovf);
                    check("timed_out", int'(bus.timed_out), cur.to);
                    check("valid_cycle", cyc, cur.cyc);
                end
            end else if (bus.width_valid && have) begin
                check("width_hold", int'(bus.width), cur.width);
            end
            pv = bus.width_valid;
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.arm = 1'b0; bus.cancel = 1'b0; bus.level = 1'b1; bus.timeout = '0;
        bus.sig_in = 1'b0; bus.ack = 1'b0;
        #12;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_valid", int'(bus.width_valid), 0);
        check("rst_width", int'(bus.width), 0);
        check("rst_overflow", int'(bus.overflow), 0);
        check("rst_timed_out", int'(bus.timed_out), 0);
        tick();
        rst_n = 1'b1;
        tick();

        capture(1'b1, 0, 1'b0, 2, 5, 0, 1'b0);
        capture(1'b1, 10, 1'b0, 20, 3, 0, 1'b0);
        capture(1'b0, 0, 1'b0, 2, 20, 0, 1'b0);
        capture(1'b1, 0, 1'b1, 4, 3, 0, 1'b0);
        capture(1'b0, 0, 1'b0, 3, 9, 50, 1'b0);
        capture(1'b1, 0, 1'b0, 1, 6, 2, 1'b1);
        capture(1'b1, 1, 1'b0, 5, 2, 0, 1'b0);
        capture(1'b1, 0, 1'b0, 1, 15, 0, 1'b0);

        // cancel mid-measure: no report may follow
        bus.sig_in = 1'b0;
        repeat (4) tick();
        bus.level = 1'b1; bus.timeout = '0; bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0; bus.sig_in = 1'b1;
        repeat (6) tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check("cancel_busy", int'(bus.busy), 0);
        check("cancel_valid", int'(bus.width_valid), 0);
        bus.sig_in = 1'b0;
        repeat (8) tick();
        check("cancel_no_report", int'(bus.width_valid), 0);

        // asynchronous reset mid-measure after a width-7 report
        capture(1'b1, 0, 1'b0, 1, 7, 0, 1'b0);
        bus.level = 1'b1; bus.timeout = '0; bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0; bus.sig_in = 1'b1;
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", int'(bus.busy), 0);
        check("arst_valid", int'(bus.width_valid), 0);
        check("arst_width", int'(bus.width), 0);
        check("arst_overflow", int'(bus.overflow), 0);
        check("arst_timed_out", int'(bus.timed_out), 0);
        #2 rst_n = 1'b1;
        bus.sig_in = 1'b0;
        tick();
        capture(1'b1, 0, 1'b0, 2, 4, 0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            capture(1'($urandom), ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, MAX)),
                    1'($urandom), int'($urandom_range(1, 12)), int'($urandom_range(1, 22)),
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

        repeat (4) tick();
        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
